// File: rtl/cluster_periph_req_demux_pkg.sv
// Shared definitions for the cluster peripheral request demux.
// - Peripheral plug IDs. The event unit owns two 1 KiB windows, 2 and 3.
// - Window decode constants and the error-slave read data.
// - The core data request and response structs.
// - sper_decode(add): returns the target plug, or SPER_TGT_ERR for an unmapped window.
package cluster_periph_req_demux_pkg;

    localparam int NB_SPERIPHS   = 10;
    localparam int SPER_ADDR_LSB = 10;
    localparam int SPER_IDX_W    = 4;
    localparam logic [31:0] SPER_ERR_RDATA = 32'hBADACCE5;

    localparam int SPER_EOC_ID         = 0;
    localparam int SPER_TIMER_ID       = 1;
    localparam int SPER_EVENT_U_ID     = 2;
    localparam int SPER_HWPE_ID        = 4;
    localparam int SPER_ICACHE_CTRL_ID = 5;
    localparam int SPER_DMA_CL_ID      = 6;
    localparam int SPER_DMA_FC_ID      = 7;
    localparam int SPER_HMR_ID         = 8;
    localparam int SPER_EXT_ID         = 9;
    localparam int SPER_ERROR_ID       = 10;

    typedef logic [SPER_IDX_W-1:0] sper_tgt_t;

    // The error slave takes the first index past the last real plug.
    localparam sper_tgt_t SPER_TGT_ERR = sper_tgt_t'(NB_SPERIPHS);

    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        wen;
        logic [31:0] data;
        logic [3:0]  be;
    } core_data_req_t;

    typedef struct packed {
        logic        gnt;
        logic        r_valid;
        logic [31:0] r_data;
    } core_data_rsp_t;

    function automatic sper_tgt_t sper_decode(input logic [31:0] add);
        sper_tgt_t idx;
        idx = add[SPER_ADDR_LSB +: SPER_IDX_W];
        if (idx == 4'd2 || idx == 4'd3)
            sper_decode = sper_tgt_t'(SPER_EVENT_U_ID);
        else if (idx < SPER_TGT_ERR)
            sper_decode = idx;
        else
            sper_decode = SPER_TGT_ERR;
    endfunction

endpackage

// File: rtl/cluster_periph_req_demux_if.sv
// Bus bundle between the core data port and the peripheral plugs.
// - slave  : demux side. Takes the core request and the plug responses,
//            drives the core response and the plug requests.
// - master : environment side. Drives the core request and the plug responses.
interface cluster_periph_req_demux_if;
    import cluster_periph_req_demux_pkg::*;

    core_data_req_t                   core_req_i;
    core_data_rsp_t                   core_rsp_o;
    core_data_req_t [NB_SPERIPHS-1:0] periph_req_o;
    core_data_rsp_t [NB_SPERIPHS-1:0] periph_rsp_i;

    modport slave  (input  core_req_i, periph_rsp_i, output core_rsp_o, periph_req_o);
    modport master (output core_req_i, periph_rsp_i, input  core_rsp_o, periph_req_o);
endinterface

// File: rtl/cluster_periph_err_slv.sv
// Error slave for unmapped peripheral windows.
// - Grants every request immediately.
// - Answers each accepted request one cycle later with SPER_ERR_RDATA.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   i_req         a request to the error window was accepted this cycle
//   o_gnt         constant grant
//   o_r_valid     response strobe, one cycle after i_req
//   o_r_data      error read data
module cluster_periph_err_slv
    import cluster_periph_req_demux_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_req,
    output logic        o_gnt,
    output logic        o_r_valid,
    output logic [31:0] o_r_data
);
    logic r_err_pend;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_err_pend <= 1'b0;
        else       r_err_pend <= i_req;
    end

    assign o_gnt     = 1'b1;
    assign o_r_valid = r_err_pend;
    assign o_r_data  = SPER_ERR_RDATA;
endmodule

// File: rtl/cluster_periph_req_demux.sv
// Demultiplexes one core data port onto the cluster peripheral plugs.
// - Decodes the 1 KiB window index and routes each request to a single plug.
// - Unmapped windows go to the internal error slave.
// - All outstanding transactions share one target, so responses are returned
//   in order with no reorder buffer.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   bus           slave modport: core_req_i/core_rsp_o, periph_req_o[]/periph_rsp_i[]
//   busy_o        at least one accepted request is still unanswered
module cluster_periph_req_demux
    import cluster_periph_req_demux_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    cluster_periph_req_demux_if.slave   bus,
    output logic                        busy_o
);
    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]       r_cnt;
    sper_tgt_t              r_cur_tgt;
    logic                   r_post_rst;

    sper_tgt_t              w_tgt;
    logic                   w_allow, w_gnt_sel, w_acc, w_rv_sel, w_rv;
    logic [31:0]            w_rdata_sel;
    logic                   w_err_req, w_err_gnt, w_err_rv;
    logic [31:0]            w_err_rdata;
    logic [NB_SPERIPHS-1:0] w_stray;

    assign w_tgt = sper_decode(bus.core_req_i.add);

    // A new target may only be opened when the pipe is empty.
    // Reusing the current target keeps the responses in order.
    assign w_allow = !rst_i && (r_cnt < CNT_MAX) && (r_cnt == '0 || w_tgt == r_cur_tgt);

    always_comb begin
        w_gnt_sel   = (w_tgt == SPER_TGT_ERR) ? w_err_gnt : 1'b0;
        w_rv_sel    = (r_cur_tgt == SPER_TGT_ERR) ? w_err_rv : 1'b0;
        w_rdata_sel = w_err_rdata;
        w_stray     = '0;
        for (int p = 0; p < NB_SPERIPHS; p++) begin
            bus.periph_req_o[p] = '0;
            if (w_tgt == sper_tgt_t'(p)) begin
                w_gnt_sel = bus.periph_rsp_i[p].gnt;
                if (w_allow) bus.periph_req_o[p] = bus.core_req_i;
            end
            if (r_cur_tgt == sper_tgt_t'(p)) begin
                w_rv_sel    = bus.periph_rsp_i[p].r_valid;
                w_rdata_sel = bus.periph_rsp_i[p].r_data;
            end
            // A late answer to a request killed by reset is expected.
            // It is tolerated until the next accept.
            w_stray[p] = bus.periph_rsp_i[p].r_valid && !rst_i &&
                         ((r_cnt == '0) ? !r_post_rst : (r_cur_tgt != sper_tgt_t'(p)));
        end
    end

    assign w_acc     = w_allow && bus.core_req_i.req && w_gnt_sel;
    assign w_rv      = !rst_i && (r_cnt != '0) && w_rv_sel;
    assign w_err_req = w_acc && (w_tgt == SPER_TGT_ERR);

    always_comb begin
        bus.core_rsp_o         = '0;
        bus.core_rsp_o.gnt     = w_allow && w_gnt_sel;
        bus.core_rsp_o.r_valid = w_rv;
        bus.core_rsp_o.r_data  = w_rdata_sel;
    end

    cluster_periph_err_slv u_err_slv (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_req     (w_err_req),
        .o_gnt     (w_err_gnt),
        .o_r_valid (w_err_rv),
        .o_r_data  (w_err_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_cur_tgt  <= '0;
            r_post_rst <= 1'b1;
        end else begin
            if (w_acc) begin
                r_cur_tgt  <= w_tgt;
                r_post_rst <= 1'b0;
            end
            case ({w_acc, w_rv})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign busy_o = (r_cnt != '0);

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i) r_cnt <= CNT_MAX);
    a_no_stray:  assert property (@(posedge clk_i) disable iff (rst_i) w_stray == '0);
endmodule
